// File: rtl/seq_detector_bcd.sv
// seq_detector_bcd: serial detector for the pattern 01[0*]1.
// It has a run-time overlap mode and an optional limit on the zero gap.
// Each detection drives an N-digit BCD counter with a sticky overflow flag.
// Every counter digit has its own active-low 7-segment decode.
// Optional build macro SEQ_DET_REG_Z_EN: when defined, z is registered and goes
// high for one cycle after the sampling edge. When undefined, z is the
// combinational Mealy output.
module seq_detector_bcd #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MAX_GAP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  sig_to_test,
  input  logic                  overlap,
  input  logic                  clr_count,
  output logic                  z,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   disp,
  output logic                  ovf
);

  typedef enum logic [1:0] {StStart, StGot0, StGot01, StGap} state_e;

  // In unlimited mode the gap counter is a don't-care, so one saturating bit suffices.
  localparam int unsigned GapW = (MAX_GAP < 2) ? 1 : $clog2(MAX_GAP + 1);
  localparam logic [GapW-1:0] GapLimit = GapW'(MAX_GAP);

  state_e              state_q, state_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic [4*DIGITS-1:0] count_q, count_inc;
  logic                ovf_q;
  logic                det;
  logic                carry;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // FSM and gap counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStart;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic and Mealy detect.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    det     = ena & sig_to_test & ((state_q == StGot01) | (state_q == StGap));
    if (ena) begin
      case (state_q)
        StStart: if (!sig_to_test) state_d = StGot0;
        StGot0:  if (sig_to_test) state_d = StGot01;
        StGot01: begin
          if (sig_to_test) begin
            // Last two bits are "11": nothing reusable in either mode.
            state_d = StStart;
          end else begin
            state_d = StGap;
            gap_d   = GapW'(1);
          end
        end
        StGap: begin
          if (sig_to_test) begin
            state_d = overlap ? StGot01 : StStart;
            gap_d   = '0;
          end else if (MAX_GAP == 0) begin
            if (gap_q != '1) gap_d = gap_q + 1'b1;
          end else if (gap_q < GapLimit) begin
            gap_d = gap_q + 1'b1;
          end else begin
            // Gap too long: the trailing 0 can still begin a new match.
            state_d = StGot0;
            gap_d   = '0;
          end
        end
        default: begin
          state_d = StStart;
          gap_d   = '0;
        end
      endcase
    end
  end

  // BCD increment with ripple carry; a carry out of the top digit is an overflow.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          count_inc[4*k +: 4] = 4'd0;
        end else begin
          count_inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Detection counter and sticky overflow; clear wins over a coincident detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr_count) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (det) begin
      count_q <= count_inc;
      if (carry) ovf_q <= 1'b1;
    end
  end

  // Per-digit 7-segment decode of the count.
  always_comb begin
    disp = '1;
    for (int k = 0; k < DIGITS; k++) begin
      disp[7*k +: 7] = seg7(count_q[4*k +: 4]);
    end
  end

`ifdef SEQ_DET_REG_Z_EN
  logic z_q;

  // Registered detect flag, high the cycle after the sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) z_q <= 1'b0;
    else     z_q <= det;
  end

  assign z = z_q;
`else
  assign z = det;
`endif

  assign count_bcd = count_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_detector_bcd.sv
// Directed bench for seq_detector_bcd.
// It runs two instances side by side: one with an unlimited gap and one with MAX_GAP=1.
module tb_seq_detector_bcd;

  logic        clk = 1'b0;
  logic        rst, ena, sig_to_test, overlap, clr_count;
  logic        z_u, z_g, ovf_u, ovf_g;
  logic [7:0]  cnt_u, cnt_g;
  logic [13:0] disp_u, disp_g;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] zvu, zvg;
  logic        zu, zg;

  always #5 clk = ~clk;

  seq_detector_bcd #(.DIGITS(2), .MAX_GAP(0)) dut_u (
    .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig_to_test), .overlap(overlap),
    .clr_count(clr_count), .z(z_u), .count_bcd(cnt_u), .disp(disp_u), .ovf(ovf_u)
  );

  seq_detector_bcd #(.DIGITS(2), .MAX_GAP(1)) dut_g (
    .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig_to_test), .overlap(overlap),
    .clr_count(clr_count), .z(z_g), .count_bcd(cnt_g), .disp(disp_g), .ovf(ovf_g)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit per clock. z is sampled where it is valid for the build in use.
  task automatic drive(input logic b, output logic zs_u, output logic zs_g);
    @(negedge clk);
    sig_to_test = b;
    #1;
`ifndef SEQ_DET_REG_Z_EN
    zs_u = z_u;
    zs_g = z_g;
`endif
    @(posedge clk);
    #1;
`ifdef SEQ_DET_REG_Z_EN
    zs_u = z_u;
    zs_g = z_g;
`endif
  endtask

  // Bit i of the stream is s[n-1-i], so the first bit is the leftmost one.
  task automatic run_stream(input logic [23:0] s, input int n,
                            output logic [23:0] vu, output logic [23:0] vg);
    logic a, b;
    vu = '0;
    vg = '0;
    for (int i = 0; i < n; i++) begin
      drive(s[n-1-i], a, b);
      vu[i] = a;
      vg[i] = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sig_to_test = 1'b0; clr_count = 1'b0; ena = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] stream;
    stream      = 24'b000100110001011101010011;
    rst         = 1'b1;
    ena         = 1'b1;
    sig_to_test = 1'b1;
    overlap     = 1'b0;
    clr_count   = 1'b0;
    #3;
    check("rst_count", cnt_u, 8'h00);
    check("rst_ovf", ovf_u, 1'b0);
    check("rst_disp", disp_u, 14'b1000000_1000000);
    check("rst_z", z_u, 1'b0);
    do_reset();

    // Non-overlapping detection.
    overlap = 1'b0;
    run_stream(stream, 24, zvu, zvg);
    check("nonovl_z", zvu, 24'h882040);
    check("nonovl_count", cnt_u, 8'h04);
    check("nonovl_disp0", disp_u[6:0], 7'b0011001);
    check("nonovl_disp1", disp_u[13:7], 7'b1000000);
    check("nonovl_ovf", ovf_u, 1'b0);

    // Overlapping detection.
    do_reset();
    overlap = 1'b1;
    run_stream(stream, 24, zvu, zvg);
    check("ovl_z", zvu, 24'hC860C0);
    check("ovl_count", cnt_u, 8'h07);
    check("ovl_disp0", disp_u[6:0], 7'b1111000);

    // Gap limit: MAX_GAP=1 abandons at index 3; unlimited detects at index 4.
    do_reset();
    overlap = 1'b0;
    run_stream(24'b010011, 6, zvu, zvg);
    check("gap_lim_z", zvg[5:0], 6'b100000);
    check("gap_lim_count", cnt_g, 8'h01);
    check("gap_unl_z", zvu[5:0], 6'b010000);

    // Overflow.
    do_reset();
    for (int i = 0; i < 99; i++) begin
      drive(1'b0, zu, zg);
      drive(1'b1, zu, zg);
      drive(1'b1, zu, zg);
    end
    check("ovf_count99", cnt_u, 8'h99);
    check("ovf_pre", ovf_u, 1'b0);
    check("ovf_disp99", disp_u, 14'b0010000_0010000);
    drive(1'b0, zu, zg);
    drive(1'b1, zu, zg);
    drive(1'b1, zu, zg);
    check("ovf_wrap_count", cnt_u, 8'h00);
    check("ovf_set", ovf_u, 1'b1);
    drive(1'b0, zu, zg);
    check("ovf_sticky", ovf_u, 1'b1);
    clr_count = 1'b1;
    drive(1'b0, zu, zg);
    clr_count = 1'b0;
    check("ovf_clr", ovf_u, 1'b0);

    // Enable: state and output hold while ena is low.
    do_reset();
    drive(1'b0, zu, zg);
    ena = 1'b0;
    drive(1'b1, zu, zg);
    check("ena_off_z0", zu, 1'b0);
    ena = 1'b1;
    drive(1'b1, zu, zg);
    check("ena_held_got0", zu, 1'b0);
    ena = 1'b0;
    drive(1'b1, zu, zg);
    check("ena_off_z1", zu, 1'b0);
    ena = 1'b1;
    drive(1'b1, zu, zg);
    check("ena_detect", zu, 1'b1);
    check("ena_count", cnt_u, 8'h01);

    // Clear coincident with detection.
    drive(1'b0, zu, zg);
    drive(1'b1, zu, zg);
    clr_count = 1'b1;
    drive(1'b1, zu, zg);
    clr_count = 1'b0;
    check("clr_coinc_z", zu, 1'b1);
    check("clr_coinc_count", cnt_u, 8'h00);

    // Asynchronous reset while in GAP.
    drive(1'b0, zu, zg);
    drive(1'b1, zu, zg);
    drive(1'b1, zu, zg);
    drive(1'b0, zu, zg);
    drive(1'b1, zu, zg);
    drive(1'b0, zu, zg);
    check("pre_rst_count", cnt_u, 8'h01);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", cnt_u, 8'h00);
    check("async_rst_z", z_u, 1'b0);
    rst = 1'b0;
    drive(1'b1, zu, zg);
    check("post_rst_no_det", zu, 1'b0);
    check("post_rst_count", cnt_u, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
